// File: rtl/ct_ifu_ibuf_queue.sv
// Instruction-buffer queue: circular array of halfword entries fed by the IFU
// fetch path, presenting the oldest OUT_NUM halfwords to decode each cycle.
module ct_ifu_ibuf_queue #(
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 16,
  parameter int PC_W     = 15,
  parameter int IN_NUM   = 8,
  parameter int OUT_NUM  = 6,
  parameter int AFULL_TH = 20,
  localparam int CN_W    = $clog2(IN_NUM + 1),
  localparam int RN_W    = $clog2(OUT_NUM + 1),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst,
  input  logic                      ibuf_flush,
  input  logic                      create_vld,
  input  logic [CN_W-1:0]           create_num,
  input  logic [IN_NUM*DATA_W-1:0]  create_data,
  input  logic [IN_NUM-1:0]         create_start32,
  input  logic [IN_NUM-1:0]         create_expt,
  input  logic [PC_W-1:0]           create_pc,
  output logic                      create_ready,
  input  logic [RN_W-1:0]           retire_num,
  output logic [OUT_NUM-1:0]        out_vld,
  output logic [OUT_NUM*DATA_W-1:0] out_data,
  output logic [OUT_NUM-1:0]        out_start32,
  output logic [OUT_NUM-1:0]        out_expt,
  output logic [OUT_NUM*PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]          entry_cnt,
  output logic                      ibuf_empty,
  output logic                      ibuf_afull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;

  logic [PTR_W-1:0]  rptr_reg, rptr_next;
  logic [PTR_W-1:0]  wptr_reg, wptr_next;
  logic [CNT_W-1:0]  entry_cnt_reg, entry_cnt_next;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DEPTH-1:0]  start32_mem;
  logic [DEPTH-1:0]  expt_mem;

  logic              create_acc;
  logic [CNT_W-1:0]  acc_num;
  logic [CNT_W-1:0]  eff_retire;
  logic [DEPTH-1:0]  wr_en;
  logic [SEL_W-1:0]  wr_sel    [DEPTH];
  logic [DATA_W-1:0] create_hw [IN_NUM];

  genvar gi;

  generate
    for (gi = 0; gi < IN_NUM; gi++) begin : g_in_unpack
      assign create_hw[gi] = create_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ready looks only at registered occupancy so it never depends on same-cycle retire.
  assign create_ready = ~cpurst & (entry_cnt_reg <= CNT_W'(DEPTH - IN_NUM));
  assign create_acc   = create_vld & create_ready & ~ibuf_flush;

  always_comb begin
    acc_num        = create_acc ? CNT_W'(create_num) : '0;
    eff_retire     = CNT_W'(retire_num);
    if (eff_retire > entry_cnt_reg)
      eff_retire = entry_cnt_reg;
    if (eff_retire > CNT_W'(OUT_NUM))
      eff_retire = CNT_W'(OUT_NUM);
    rptr_next      = rptr_reg + eff_retire[PTR_W-1:0];
    wptr_next      = wptr_reg + acc_num[PTR_W-1:0];
    entry_cnt_next = entry_cnt_reg + acc_num - eff_retire;
    if (ibuf_flush) begin
      rptr_next      = '0;
      wptr_next      = '0;
      entry_cnt_next = '0;
    end
  end

  // Each entry finds its offset from wptr; offsets below create_num take that halfword.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr
      logic [PTR_W-1:0] offs;
      assign offs       = PTR_W'(gi) - wptr_reg;
      assign wr_en[gi]  = create_acc & ({1'b0, offs} < CNT_W'(create_num));
      assign wr_sel[gi] = offs[SEL_W-1:0];
    end
  endgenerate

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rptr_reg      <= '0;
      wptr_reg      <= '0;
      entry_cnt_reg <= '0;
      start32_mem   <= '0;
      expt_mem      <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        data_mem[e] <= '0;
        pc_mem[e]   <= '0;
      end
    end else begin
      rptr_reg      <= rptr_next;
      wptr_reg      <= wptr_next;
      entry_cnt_reg <= entry_cnt_next;
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_en[e]) begin
          data_mem[e]    <= create_hw[wr_sel[e]];
          start32_mem[e] <= create_start32[wr_sel[e]];
          expt_mem[e]    <= create_expt[wr_sel[e]];
          pc_mem[e]      <= create_pc + PC_W'(wr_sel[e]);
        end
      end
    end
  end

  // Lanes read oldest-first from rptr; invalid lanes are forced to zero.
  generate
    for (gi = 0; gi < OUT_NUM; gi++) begin : g_lane
      logic [PTR_W-1:0] idx;
      logic             vld;
      assign idx                          = rptr_reg + PTR_W'(gi);
      assign vld                          = CNT_W'(gi) < entry_cnt_reg;
      assign out_vld[gi]                  = vld;
      assign out_data[gi*DATA_W +: DATA_W] = vld ? data_mem[idx] : '0;
      assign out_pc[gi*PC_W +: PC_W]      = vld ? pc_mem[idx] : '0;
      assign out_start32[gi]              = vld & start32_mem[idx];
      assign out_expt[gi]                 = vld & expt_mem[idx];
    end
  endgenerate

  assign entry_cnt  = entry_cnt_reg;
  assign ibuf_empty = (entry_cnt_reg == '0);
  assign ibuf_afull = (entry_cnt_reg >= CNT_W'(AFULL_TH));

endmodule

// File: tb/tb_ct_ifu_ibuf_queue.sv
// Bench for ct_ifu_ibuf_queue: directed scenarios plus random traffic checked
// against an ordered-queue model of the buffer contents.
module tb_ct_ifu_ibuf_queue;
  localparam int DEPTH    = 32;
  localparam int DATA_W   = 16;
  localparam int PC_W     = 15;
  localparam int IN_NUM   = 8;
  localparam int OUT_NUM  = 6;
  localparam int AFULL_TH = 20;
  localparam int CN_W     = $clog2(IN_NUM + 1);
  localparam int RN_W     = $clog2(OUT_NUM + 1);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic                      forever_cpuclk = 1'b0;
  logic                      cpurst = 1'b1;
  logic                      ibuf_flush = 1'b0;
  logic                      create_vld = 1'b0;
  logic [CN_W-1:0]           create_num = '0;
  logic [IN_NUM*DATA_W-1:0]  create_data = '0;
  logic [IN_NUM-1:0]         create_start32 = '0;
  logic [IN_NUM-1:0]         create_expt = '0;
  logic [PC_W-1:0]           create_pc = '0;
  logic                      create_ready;
  logic [RN_W-1:0]           retire_num = '0;
  logic [OUT_NUM-1:0]        out_vld;
  logic [OUT_NUM*DATA_W-1:0] out_data;
  logic [OUT_NUM-1:0]        out_start32;
  logic [OUT_NUM-1:0]        out_expt;
  logic [OUT_NUM*PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]          entry_cnt;
  logic                      ibuf_empty;
  logic                      ibuf_afull;

  ct_ifu_ibuf_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W),
    .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .AFULL_TH(AFULL_TH)
  ) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst), .ibuf_flush(ibuf_flush),
    .create_vld(create_vld), .create_num(create_num), .create_data(create_data),
    .create_start32(create_start32), .create_expt(create_expt), .create_pc(create_pc),
    .create_ready(create_ready), .retire_num(retire_num), .out_vld(out_vld),
    .out_data(out_data), .out_start32(out_start32), .out_expt(out_expt),
    .out_pc(out_pc), .entry_cnt(entry_cnt), .ibuf_empty(ibuf_empty),
    .ibuf_afull(ibuf_afull)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
    logic [PC_W-1:0]   pc;
  } hw_t;

  hw_t mq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic logic [DATA_W-1:0] lane_data(input int i);
    return out_data[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [PC_W-1:0] lane_pc(input int i);
    return out_pc[i*PC_W +: PC_W];
  endfunction

  // Drive one cycle of inputs, advance the queue model across the edge, settle.
  task automatic step(input logic rst, input logic flush, input logic cvld,
                      input int cnum, input int rnum,
                      input logic [IN_NUM*DATA_W-1:0] cdata,
                      input logic [IN_NUM-1:0] cs32, input logic [IN_NUM-1:0] cexpt,
                      input logic [PC_W-1:0] cpc);
    bit  pre_ready;
    int  eff;
    hw_t h;
    assert (cnum <= IN_NUM) else $error("illegal create_num %0d", cnum);
    cpurst = rst; ibuf_flush = flush; create_vld = cvld;
    create_num = CN_W'(cnum); retire_num = RN_W'(rnum);
    create_data = cdata; create_start32 = cs32; create_expt = cexpt; create_pc = cpc;
    pre_ready = !rst && ((DEPTH - mq.size()) >= IN_NUM);
    @(posedge forever_cpuclk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      eff = rnum;
      if (eff > mq.size()) eff = mq.size();
      if (eff > OUT_NUM) eff = OUT_NUM;
      repeat (eff) void'(mq.pop_front());
      if (cvld && pre_ready) begin
        for (int i = 0; i < cnum; i++) begin
          h.d  = cdata[i*DATA_W +: DATA_W];
          h.s  = cs32[i];
          h.e  = cexpt[i];
          h.pc = cpc + PC_W'(i);
          mq.push_back(h);
        end
      end
    end
    #1;
    n_checks++;
    if (int'(entry_cnt) > DEPTH) begin
      n_fail++; $display("FAIL occupancy_bound: entry_cnt=%0d required <= %0d", entry_cnt, DEPTH);
    end
  endtask

  task automatic idle(input int rnum);
    step(1'b0, 1'b0, 1'b0, 0, rnum, '0, '0, '0, '0);
  endtask

  task automatic create(input int cnum, input int rnum, input logic [DATA_W-1:0] base,
                        input logic [PC_W-1:0] pc);
    logic [IN_NUM*DATA_W-1:0] cd;
    for (int i = 0; i < IN_NUM; i++) cd[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    step(1'b0, 1'b0, 1'b1, cnum, rnum, cd, '0, '0, pc);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    logic [IN_NUM*DATA_W-1:0] cd;
    for (int i = 0; i < IN_NUM; i++) cd[i*DATA_W +: DATA_W] = 16'h7000 + DATA_W'(i);
    step(1'b1, 1'b0, 1'b1, 8, 0, cd, '1, '1, 15'h10);
    step(1'b1, 1'b0, 1'b1, 8, 0, cd, '1, '1, 15'h10);
    n_checks++; if (create_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held: got %b required 0", create_ready); end
    idle(0);
    n_checks++; if (out_vld !== '0) begin n_fail++; $display("FAIL reset_out_vld: got %b required 0", out_vld); end
    n_checks++; if (entry_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", entry_cnt); end
    n_checks++; if (ibuf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", ibuf_empty); end
    n_checks++; if (ibuf_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b required 0", ibuf_afull); end
    n_checks++; if (create_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b required 1", create_ready); end
    n_checks++; if (out_data !== '0 || out_pc !== '0 || out_start32 !== '0 || out_expt !== '0) begin
      n_fail++; $display("FAIL reset_lanes_zero: data=%h pc=%h s32=%b expt=%b required all 0", out_data, out_pc, out_start32, out_expt);
    end
  endtask

  task automatic test_single_create();
    logic [IN_NUM*DATA_W-1:0] cd;
    do_reset();
    for (int i = 0; i < IN_NUM; i++) cd[i*DATA_W +: DATA_W] = (i < 5) ? 16'h1111 * DATA_W'(i + 1) : 16'hFFFF;
    step(1'b0, 1'b0, 1'b1, 5, 0, cd, 8'b0000_0100, 8'b1001_0000, 15'h100);
    n_checks++; if (out_vld !== 6'b011111) begin n_fail++; $display("FAIL single_vld: got %b required 011111", out_vld); end
    n_checks++; if (lane_data(4) !== 16'h5555) begin n_fail++; $display("FAIL single_lane4_data: got %h required 5555", lane_data(4)); end
    n_checks++; if (lane_pc(4) !== 15'h104) begin n_fail++; $display("FAIL single_lane4_pc: got %h required 104", lane_pc(4)); end
    n_checks++; if (entry_cnt !== 6'd5) begin n_fail++; $display("FAIL single_cnt: got %0d required 5", entry_cnt); end
    n_checks++; if (out_start32 !== 6'b000100) begin n_fail++; $display("FAIL single_start32: got %b required 000100", out_start32); end
    n_checks++; if (out_expt !== 6'b010000) begin n_fail++; $display("FAIL single_expt: got %b required 010000", out_expt); end
    n_checks++; if (lane_data(5) !== 16'h0) begin n_fail++; $display("FAIL single_lane5_masked: got %h required 0", lane_data(5)); end
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      create(8, 0, DATA_W'(16'h2000 + 16 * k), PC_W'(32 * k));
      n_checks++; if (int'(entry_cnt) != 8 * k) begin n_fail++; $display("FAIL fill_cnt_%0d: got %0d required %0d", k, entry_cnt, 8 * k); end
      n_checks++; if (ibuf_afull !== (8 * k >= AFULL_TH)) begin n_fail++; $display("FAIL fill_afull_%0d: got %b required %b", k, ibuf_afull, (8 * k >= AFULL_TH)); end
      n_checks++; if (create_ready !== (k < 4)) begin n_fail++; $display("FAIL fill_ready_%0d: got %b required %b", k, create_ready, (k < 4)); end
    end
    create(8, 0, 16'h2F00, 15'h0);
    n_checks++; if (entry_cnt !== 6'd32) begin n_fail++; $display("FAIL backpressure_cnt: got %0d required 32", entry_cnt); end
    idle(6);
    n_checks++; if (entry_cnt !== 6'd26 || create_ready !== 1'b0) begin n_fail++; $display("FAIL drain_26: cnt=%0d ready=%b required 26/0", entry_cnt, create_ready); end
    n_checks++; if (lane_data(0) !== mq[0].d) begin n_fail++; $display("FAIL drain_lane0: got %h required %h", lane_data(0), mq[0].d); end
    idle(6);
    n_checks++; if (entry_cnt !== 6'd20 || create_ready !== 1'b1 || ibuf_afull !== 1'b1) begin
      n_fail++; $display("FAIL drain_20: cnt=%0d ready=%b afull=%b required 20/1/1", entry_cnt, create_ready, ibuf_afull);
    end
    idle(1);
    n_checks++; if (ibuf_afull !== 1'b0) begin n_fail++; $display("FAIL drain_19_afull: got %b required 0", ibuf_afull); end
  endtask

  task automatic test_wrap();
    do_reset();
    create(4, 0, 16'h3000, 15'h0);
    for (int k = 0; k < 6; k++) create(4, 4, DATA_W'(16'h3100 + 16 * k), 15'h0);
    n_checks++; if (entry_cnt !== 6'd4) begin n_fail++; $display("FAIL wrap_setup_cnt: got %0d required 4", entry_cnt); end
    create(8, 6, 16'hA000, 15'h7FFE);
    n_checks++; if (entry_cnt !== 6'd8 || out_vld !== 6'h3F) begin n_fail++; $display("FAIL wrap_cnt: cnt=%0d vld=%b required 8/111111", entry_cnt, out_vld); end
    n_checks++; if (lane_data(0) !== 16'hA000 || lane_pc(0) !== 15'h7FFE) begin
      n_fail++; $display("FAIL wrap_lane0: data=%h pc=%h required A000/7FFE", lane_data(0), lane_pc(0));
    end
    n_checks++; if (lane_pc(2) !== 15'h0) begin n_fail++; $display("FAIL wrap_pc_rollover: got %h required 0", lane_pc(2)); end
    n_checks++; if (lane_data(5) !== 16'hA005) begin n_fail++; $display("FAIL wrap_lane5: got %h required A005", lane_data(5)); end
    idle(6);
    n_checks++; if (entry_cnt !== 6'd2 || out_vld !== 6'b000011) begin n_fail++; $display("FAIL wrap_drain: cnt=%0d vld=%b required 2/000011", entry_cnt, out_vld); end
    n_checks++; if (lane_data(0) !== 16'hA006 || lane_data(1) !== 16'hA007 || lane_pc(1) !== 15'h5) begin
      n_fail++; $display("FAIL wrap_tail: d0=%h d1=%h pc1=%h required A006/A007/5", lane_data(0), lane_data(1), lane_pc(1));
    end
  endtask

  task automatic test_flush();
    do_reset();
    create(8, 0, 16'hB000, 15'h0);
    create(2, 0, 16'hB100, 15'h8);
    n_checks++; if (entry_cnt !== 6'd10) begin n_fail++; $display("FAIL flush_setup: got %0d required 10", entry_cnt); end
    step(1'b0, 1'b1, 1'b1, 8, 3, '1, '0, '0, 15'h55);
    n_checks++; if (entry_cnt !== '0 || out_vld !== '0 || ibuf_empty !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: cnt=%0d vld=%b empty=%b required 0/0/1", entry_cnt, out_vld, ibuf_empty);
    end
    create(3, 0, 16'hC000, 15'h40);
    n_checks++; if (entry_cnt !== 6'd3 || out_vld !== 6'b000111 || lane_data(0) !== 16'hC000 || lane_pc(2) !== 15'h42) begin
      n_fail++; $display("FAIL flush_refill: cnt=%0d vld=%b d0=%h pc2=%h required 3/000111/C000/42", entry_cnt, out_vld, lane_data(0), lane_pc(2));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    create(8, 0, 16'hD000, 15'h0);
    create(4, 0, 16'hD100, 15'h8);
    n_checks++; if (entry_cnt !== 6'd12) begin n_fail++; $display("FAIL midrst_setup: got %0d required 12", entry_cnt); end
    step(1'b1, 1'b0, 1'b1, 8, 2, '1, '1, '1, 15'h3);
    n_checks++; if (entry_cnt !== '0 || out_vld !== '0 || create_ready !== 1'b0 || ibuf_empty !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: cnt=%0d vld=%b ready=%b empty=%b required 0/0/0/1", entry_cnt, out_vld, create_ready, ibuf_empty);
    end
    n_checks++; if (out_data !== '0 || out_pc !== '0) begin n_fail++; $display("FAIL midrst_lanes: data=%h pc=%h required 0", out_data, out_pc); end
    idle(0);
    n_checks++; if (entry_cnt !== '0 || create_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release: cnt=%0d ready=%b required 0/1", entry_cnt, create_ready); end
  endtask

  task automatic test_random();
    logic [IN_NUM*DATA_W-1:0] cd;
    logic [DATA_W-1:0] ed;
    logic [PC_W-1:0]   ep;
    logic              ev, es, ee;
    int cn, rn;
    bit rst, fl, cv;
    do_reset();
    for (int r = 0; r < 600; r++) begin
      rst = ($urandom_range(149) == 0);
      fl  = ($urandom_range(39) == 0);
      cv  = ($urandom_range(9) < 7);
      cn  = $urandom_range(IN_NUM);
      rn  = ((r % 100) < 50) ? $urandom_range(2) : $urandom_range(OUT_NUM);
      for (int i = 0; i < IN_NUM; i++) cd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      step(rst, fl, cv, cn, rn, cd, IN_NUM'($urandom), IN_NUM'($urandom), PC_W'($urandom));
      n_checks++; if (int'(entry_cnt) != mq.size()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d required %0d", r, entry_cnt, mq.size()); end
      n_checks++; if (create_ready !== (!cpurst && (DEPTH - mq.size()) >= IN_NUM)) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b required %b", r, create_ready, (!cpurst && (DEPTH - mq.size()) >= IN_NUM));
      end
      n_checks++; if (ibuf_empty !== (mq.size() == 0) || ibuf_afull !== (mq.size() >= AFULL_TH)) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: empty=%b afull=%b size=%0d", r, ibuf_empty, ibuf_afull, mq.size());
      end
      for (int i = 0; i < OUT_NUM; i++) begin
        ev = 1'b0; ed = '0; ep = '0; es = 1'b0; ee = 1'b0;
        if (i < mq.size()) begin
          ev = 1'b1; ed = mq[i].d; ep = mq[i].pc; es = mq[i].s; ee = mq[i].e;
        end
        n_checks++;
        if (out_vld[i] !== ev || lane_data(i) !== ed || lane_pc(i) !== ep || out_start32[i] !== es || out_expt[i] !== ee) begin
          n_fail++;
          $display("FAIL rnd_lane[%0d].%0d: got vld=%b d=%h pc=%h s=%b e=%b required vld=%b d=%h pc=%h s=%b e=%b",
                   r, i, out_vld[i], lane_data(i), lane_pc(i), out_start32[i], out_expt[i], ev, ed, ep, es, ee);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_create();
    test_fill_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
